// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit count, blank codes
// and the active-low hex segment table.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0]            SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

    // Index = nibble value, entry = {g,f,e,d,c,b,a}, active-low.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg7_display_scanner.sv
// Eight-digit multiplexed hex display scanner with frame-aligned commit of
// new values, optional leading-zero blanking and an anode guard interval.
module seg7_display_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    input  logic                  blank_lz,
    output logic [6:0]            ledOut,
    output logic [NUM_DIGITS-1:0] Anodeselect,
    output logic                  pending,
    output logic [31:0]           active_value
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [DW-1:0]           digit_idx_q, digit_idx_d;
    logic [31:0]             shadow_q, shadow_d;
    logic [31:0]             active_q, active_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic [31:0]             upper_bits;
    logic                    blanked;
    logic                    in_guard;

    assign slot_end   = (prescaler_q == PRE_LAST);
    assign frame_end  = slot_end && (digit_idx_q == LAST_DIGIT);
    assign cur_nibble = active_q[{digit_idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    always_comb begin
        prescaler_d = slot_end ? '0 : prescaler_q + PW'(1);
        digit_idx_d = slot_end ? digit_idx_q + DW'(1) : digit_idx_q;

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        if (wr_en) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end

        // A write landing on the boundary cycle bypasses the shadow so it is
        // not held back a whole frame.
        if (frame_end) begin
            if (wr_en) begin
                active_d  = wr_data;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        upper_bits = active_q >> {digit_idx_q, 2'b00};
        blanked    = blank_lz && (digit_idx_q != '0) && (upper_bits == 32'h0);
        in_guard   = (prescaler_q < GUARD_END);

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!in_guard && !blanked) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
            seg_d = cur_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign ledOut       = seg_q;
    assign Anodeselect  = an_q;
    assign pending      = pending_q;
    assign active_value = active_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Bench for seg7_display_scanner with REFRESH_DIV=4, GUARD_CYCLES=1 (32-cycle frames).
module tb_seg7_display_scanner;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] led;
    } exp_t;

    typedef struct packed {
        logic            blank;
        logic [31:0]     data;
        logic [7:0][7:0] an;
        logic [7:0][6:0] led;
    } vec_t;

    localparam logic [7:0][7:0] AN_ALL =
        {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    localparam logic [7:0][7:0] AN_D0 =
        {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    localparam int NV = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  ledOut;
    logic [7:0]  Anodeselect;
    logic        pending;
    logic [31:0] active_value;

    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    exp_t exp_q[$];
    vec_t vecs[NV];

    seg7_display_scanner #(
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .blank_lz     (blank_lz),
        .ledOut       (ledOut),
        .Anodeselect  (Anodeselect),
        .pending      (pending),
        .active_value (active_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    // k counts edges since reset release; the DUT's scan state before edge k+1 is k.
    task automatic tick();
        @(posedge clk);
        k = reset ? 0 : k + 1;
        #1;
    endtask

    task automatic goto_state(input int s);
        for (int n = 0; n < 40 && (k % 32) != s; n++) tick();
    endtask

    task automatic do_write(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0][7:0] an, input logic [7:0][6:0] led);
        for (int d = 0; d < 8; d++) exp_q.push_back('{an: an[d], led: led[d]});
    endtask

    task automatic check_frame(input string name);
        exp_t e;
        goto_state(0);
        for (int d = 0; d < 8; d++) begin
            tick();
            chk({name, "_guard_an"}, {24'h0, Anodeselect}, 32'hFF);
            chk({name, "_guard_led"}, {25'h0, ledOut}, 32'h7F);
            tick();
            if (exp_q.size() == 0) begin
                chk({name, "_queue_empty"}, 32'h1, 32'h0);
                e = '{an: 8'h00, led: 7'h00};
            end else begin
                e = exp_q.pop_front();
            end
            chk({name, "_an"}, {24'h0, Anodeselect}, {24'h0, e.an});
            chk({name, "_led"}, {25'h0, ledOut}, {25'h0, e.led});
            tick();
            tick();
            chk({name, "_an_late"}, {24'h0, Anodeselect}, {24'h0, e.an});
            chk({name, "_led_late"}, {25'h0, ledOut}, {25'h0, e.led});
        end
    endtask

    initial begin
        logic [31:0] cur_val;
        logic        saw_a;

        vecs[0] = '{blank: 1'b0, data: 32'h12345678, an: AN_ALL,
                    led: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[1] = '{blank: 1'b1, data: 32'h000000A0,
                    an: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
                    led: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[2] = '{blank: 1'b0, data: 32'h000000A0, an: AN_ALL,
                    led: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40}};
        vecs[3] = '{blank: 1'b0, data: 32'h89ABCDEF, an: AN_ALL,
                    led: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[4] = '{blank: 1'b1, data: 32'h00000000, an: AN_D0,
                    led: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[5] = '{blank: 1'b1, data: 32'h00F00000,
                    an: {8'hFF, 8'hFF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                    led: {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{blank: 1'b1, data: 32'hFFFFFFFF, an: AN_ALL,
                    led: {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};

        // Reset and first frame of the zero value
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_an", {24'h0, Anodeselect}, 32'hFF);
        chk("rst_led", {25'h0, ledOut}, 32'h7F);
        chk("rst_pending", {31'h0, pending}, 32'h0);
        chk("rst_active", active_value, 32'h0);
        reset = 1'b0;
        push_frame(AN_ALL, {8{7'h40}});
        check_frame("rst_frame");
        cur_val = 32'h0;

        for (int i = 0; i < NV; i++) begin
            blank_lz = vecs[i].blank;
            goto_state(10);
            do_write(vecs[i].data);
            chk("vec_pending_set", {31'h0, pending}, 32'h1);
            chk("vec_active_hold", active_value, cur_val);
            push_frame(vecs[i].an, vecs[i].led);
            check_frame("vec");
            chk("vec_pending_clr", {31'h0, pending}, 32'h0);
            chk("vec_active", active_value, vecs[i].data);
            cur_val = vecs[i].data;
        end

        // Two writes in one frame: last wins, nothing shows mid-frame
        saw_a = 1'b0;
        goto_state(5);
        do_write(32'hAAAAAAAA);
        goto_state(20);
        do_write(32'h0000000F);
        for (int n = 0; n < 40 && (k % 32) != 0; n++) begin
            tick();
            if (ledOut == 7'h08) saw_a = 1'b1;
        end
        chk("tear_no_a", {31'h0, saw_a}, 32'h0);
        chk("tear_active", active_value, 32'h0000000F);
        push_frame(AN_D0, {{7{7'h7F}}, 7'h0E});
        check_frame("tear");

        // Write on the boundary cycle with a different value pending
        goto_state(8);
        do_write(32'h00000009);
        goto_state(31);
        do_write(32'h00000005);
        chk("coinc_active", active_value, 32'h00000005);
        chk("coinc_pending", {31'h0, pending}, 32'h0);
        push_frame(AN_D0, {{7{7'h7F}}, 7'h12});
        check_frame("coinc");

        // Reset mid-slot while a value is pending
        goto_state(3);
        do_write(32'h00000077);
        goto_state(6);
        chk("midrst_pending_pre", {31'h0, pending}, 32'h1);
        reset = 1'b1;
        tick();
        chk("midrst_an", {24'h0, Anodeselect}, 32'hFF);
        chk("midrst_led", {25'h0, ledOut}, 32'h7F);
        chk("midrst_active", active_value, 32'h0);
        chk("midrst_pending", {31'h0, pending}, 32'h0);
        tick();
        reset = 1'b0;
        push_frame(AN_D0, {{7{7'h7F}}, 7'h40});
        check_frame("midrst_frame");
        chk("midrst_active_after", active_value, 32'h0);

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_display_scanner.md
Name: seg7_display_scanner

Overview:
- Downstream consumer of the RISCV core's display output. It drives the 8-digit multiplexed seven-segment display through `ledOut` and `Anodeselect`.
- The core writes a 32-bit value; the block shows it as 8 hex digits, one digit slot at a time.
- A shadow/active register pair commits new values only at frame boundaries, so the display never tears mid-frame.
- Optional leading-zero blanking, plus an anode guard interval against ghosting.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; fixed at 8 for this board.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- GUARD_CYCLES, 4, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe from the core, one cycle per write.
- wr_data  in  32  value to display; nibble k drives digit k.
- blank_lz  in  1  1 = blank leading-zero digits (digit 0 is never blanked).
- ledOut  out  7  segments {g,f,e,d,c,b,a}, active-low.
- Anodeselect  out  8  digit enables, active-low, one-cold; bit k = digit k.
- pending  out  1  shadow register holds an uncommitted value.
- active_value  out  32  value currently being displayed.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of `clk`.
  - `reset` is synchronous and active-high.
  - Reset values: prescaler=0, digit_idx=0, shadow=0, active_value=0, pending=0, Anodeselect=8'hFF, ledOut=7'h7F.
  - Reset mid-scan or mid-pending discards the shadow value.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - At terminal count, digit_idx increments modulo 8 (7 wraps to 0).
- Frame boundary:
  - The cycle where prescaler=REFRESH_DIV-1 and digit_idx=7.
- Write path:
  - wr_en=1 loads shadow<=wr_data and sets pending<=1.
  - Multiple writes within a frame: last one wins.
- Commit at a frame boundary:
  - If pending=1: active_value<=shadow, pending<=0.
  - If wr_en=1 in that same cycle: active_value<=wr_data directly, pending<=0.
  - If no write is pending, active_value holds.
- Output pipeline:
  - Outputs are registered, one cycle of latency from (prescaler, digit_idx, active_value).
  - Next-cycle ledOut = hex_to_seg7(active_value[4*digit_idx +: 4]).
  - Next-cycle Anodeselect = ~(8'b1 << digit_idx), except all ones when prescaler < GUARD_CYCLES or the digit is blanked.
  - ledOut is forced to 7'h7F whenever all anodes are off.
- Leading-zero blanking:
  - Applies only when blank_lz=1.
  - Digit k (k>0) is blanked if active_value[31:4k] == 0.
  - Value 0 therefore shows a single "0" on digit 0.
- Segment table, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Scan timing: a full frame is 8*REFRESH_DIV cycles, and scanning never stalls.

Decomposition:
- Package `seg7_pkg`:
  - NUM_DIGITS constant.
  - 16-entry segment lookup constant.
  - Constants SEG_BLANK=7'h7F and AN_OFF=8'hFF.
- Sub-module `hex_to_seg7`: purely combinational, 4-bit nibble in, 7-bit active-low segments out, indexing the package table.
- Prescaler, digit counter, shadow/active registers and output registers stay in the top module.

Test Plan (REFRESH_DIV=4, GUARD_CYCLES=1 unless noted):
- Reset: hold reset 3 cycles -> Anodeselect=FF, ledOut=7F, pending=0. After release, one guard cycle of FF, then Anodeselect=FE with ledOut=40 for 3 cycles, then guard, then FD/40.
- Write 0x12345678 mid-frame:
  - pending=1 until the frame boundary, active_value unchanged until then.
  - Next frame shows FE/00 ("8"), FD/78, FB/02, F7/12, EF/19, DF/30, BF/24, 7F/79 ("1").
  - pending=0 after commit.
- Tear-free commit: during one frame write 0xAAAAAAAA then 0x0000000F -> no digit ever shows A (08). After the boundary, digit 0 shows 0E.
- blank_lz=1, value 0x000000A0 -> digit 0 FE/40, digit 1 FD/08, digits 2-7 Anodeselect=FF and ledOut=7F in their slots. With blank_lz=0, digits 2-7 show 40.
- Write coinciding with the boundary cycle: wr_data=0x00000005 with pending shadow 0x00000009 -> active_value=5, pending=0, digit 0 shows 12.
- Reset asserted mid-slot with pending=1 -> next cycle Anodeselect=FF, ledOut=7F, active_value=0, pending=0. The scan restarts at digit 0 after release.
